// File: rtl/ppu_pkg.sv
// ============================================================================
// Module      : ppu_pkg
// Description : Shared types and the NES colour-index to RGB palette.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppu_pkg;

    typedef logic [5:0] nes_color_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } replay_state_t;

    localparam logic [23:0] NES_RGB [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

endpackage

`default_nettype wire

// File: rtl/nes_rgb_lut.sv
// ============================================================================
// Module      : nes_rgb_lut
// Description : Combinational NES colour index to 24-bit RGB conversion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_rgb_lut
    import ppu_pkg::*;
(
    input  nes_color_t i_color,
    output rgb_t       o_rgb
);

    assign o_rgb = rgb_t'(NES_RGB[i_color]);

endmodule

`default_nettype wire

// File: rtl/ppu_line_buffer.sv
// ============================================================================
// Module      : ppu_line_buffer
// Description : Ping-pong scanline buffer; replays the front line with
//               horizontal pixel repetition and palette conversion to RGB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppu_line_buffer
    import ppu_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int SCALE  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(LINE_W)-1:0] wr_x,
    input  logic [5:0]                wr_color,
    input  logic                      wr_line_done,
    input  logic                      rd_start,
    input  logic                      rd_pix_en,
    output logic                      rd_busy,
    output logic                      line_ready,
    output logic                      rgb_valid,
    output logic [7:0]                red,
    output logic [7:0]                green,
    output logic [7:0]                blue,
    output logic                      overrun,
    output logic                      underrun
);

    localparam int X_W   = $clog2(LINE_W);
    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [X_W-1:0]   LAST_COL = X_W'(LINE_W - 1);
    localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(SCALE - 1);

    replay_state_t    state_q, state_d;
    logic [X_W-1:0]   col_q, col_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             front_sel_q, front_sel_d;
    logic             swap_pending_q, swap_pending_d;
    logic             line_ready_q, line_ready_d;
    logic             overrun_q, overrun_d;
    logic             underrun_q, underrun_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rgb_valid_q, rgb_valid_d;
    rgb_t             rgb_q, rgb_d;
    nes_color_t       rd_color_q;
    rgb_t             lut_rgb;
    logic             rd_issue;
    logic             last_issue;

    // Both banks share one array addressed as {bank, column}.
    nes_color_t mem [2*LINE_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{~front_sel_q, wr_x}] <= wr_color;
        end
        if (rd_issue) begin
            rd_color_q <= mem[{front_sel_q, col_q}];
        end
    end

    nes_rgb_lut u_lut (
        .i_color (rd_color_q),
        .o_rgb   (lut_rgb)
    );

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        sub_d          = sub_q;
        front_sel_d    = front_sel_q;
        swap_pending_d = swap_pending_q;
        line_ready_d   = line_ready_q;
        overrun_d      = overrun_q;
        underrun_d     = underrun_q;
        rd_issue       = (state_q == READ) && rd_pix_en;
        last_issue     = rd_issue && (col_q == LAST_COL) && (sub_q == LAST_SUB);

        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    state_d      = READ;
                    col_d        = '0;
                    sub_d        = '0;
                    line_ready_d = 1'b0;
                    if (!line_ready_q) begin
                        underrun_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_issue) begin
                    if (sub_q == LAST_SUB) begin
                        sub_d = '0;
                        col_d = col_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                    if (last_issue) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A replay starting this very cycle counts as active, so its bank is not swapped away.
        if (wr_line_done) begin
            if (swap_pending_q) begin
                overrun_d = 1'b1;
            end else if ((state_q == READ) || rd_start) begin
                swap_pending_d = 1'b1;
            end else begin
                front_sel_d  = ~front_sel_q;
                line_ready_d = 1'b1;
            end
        end

        if (last_issue && (swap_pending_q || wr_line_done)) begin
            front_sel_d    = ~front_sel_q;
            line_ready_d   = 1'b1;
            swap_pending_d = 1'b0;
        end

        rd_valid_d  = rd_issue;
        rgb_valid_d = rd_valid_q;
        rgb_d       = rd_valid_q ? lut_rgb : rgb_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            col_q          <= '0;
            sub_q          <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            line_ready_q   <= 1'b0;
            overrun_q      <= 1'b0;
            underrun_q     <= 1'b0;
            rd_valid_q     <= 1'b0;
            rgb_valid_q    <= 1'b0;
            rgb_q          <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            sub_q          <= sub_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            line_ready_q   <= line_ready_d;
            overrun_q      <= overrun_d;
            underrun_q     <= underrun_d;
            rd_valid_q     <= rd_valid_d;
            rgb_valid_q    <= rgb_valid_d;
            rgb_q          <= rgb_d;
        end
    end

    assign rd_busy    = (state_q == READ);
    assign line_ready = line_ready_q;
    assign rgb_valid  = rgb_valid_q;
    assign red        = rgb_q.red;
    assign green      = rgb_q.green;
    assign blue       = rgb_q.blue;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ppu_line_buffer.sv
// ============================================================================
// Module      : tb_ppu_line_buffer
// Description : Directed, table-driven self-checking bench for ppu_line_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppu_line_buffer;

    localparam int LINE_W = 256;
    localparam int SCALE  = 2;
    localparam int NPIX   = LINE_W * SCALE;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [5:0] wr_color;
    logic       wr_line_done;
    logic       rd_start;
    logic       rd_pix_en;
    logic       rd_busy;
    logic       line_ready;
    logic       rgb_valid;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       overrun;
    logic       underrun;

    int errors = 0;
    int checks = 0;

    logic [23:0] cap [$];

    typedef struct {
        logic [5:0]  idx;
        logic [23:0] rgb;
    } vec_t;

    vec_t vec [15];

    ppu_line_buffer #(
        .LINE_W (LINE_W),
        .SCALE  (SCALE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_color     (wr_color),
        .wr_line_done (wr_line_done),
        .rd_start     (rd_start),
        .rd_pix_en    (rd_pix_en),
        .rd_busy      (rd_busy),
        .line_ready   (line_ready),
        .rgb_valid    (rgb_valid),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rgb_valid) begin
            cap.push_back({red, green, blue});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: colour = x[5:0]; mode 1: constant c; mode 2: table indices then 0
    task automatic write_line(input int mode, input logic [5:0] c);
        for (int x = 0; x < LINE_W; x++) begin
            wr_en = 1'b1;
            wr_x  = 8'(x);
            if (mode == 0)      wr_color = 6'(x);
            else if (mode == 1) wr_color = c;
            else                wr_color = (x < 15) ? vec[x].idx : 6'h00;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        wr_line_done = 1'b1;
        tick();
        wr_line_done = 1'b0;
    endtask

    // Full replay with strobe held high; optional wr_line_done pulses at given strobe indices.
    task automatic replay(input int d1, input int d2, output int strobes, output logic ready_after);
        cap.delete();
        rd_start = 1'b1;
        tick();
        rd_start  = 1'b0;
        strobes   = 0;
        rd_pix_en = 1'b1;
        while (rd_busy && strobes < 2000) begin
            wr_line_done = (strobes == d1) || (strobes == d2);
            tick();
            strobes++;
        end
        wr_line_done = 1'b0;
        ready_after  = line_ready;
        rd_pix_en    = 1'b0;
        repeat (3) tick();
    endtask

    function automatic int count_not(input logic [23:0] v);
        int bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (i >= cap.size() || cap[i] !== v) bad++;
        end
        return bad;
    endfunction

    initial begin
        int          strobes;
        logic        rdy;
        logic        en5 [10];
        logic [23:0] pix5 [4];
        logic [23:0] exp_cur;
        int          nseen;
        logic        expv;

        vec[0]  = '{6'h00, 24'h7C7C7C};
        vec[1]  = '{6'h01, 24'h0000FC};
        vec[2]  = '{6'h20, 24'hF8F8F8};
        vec[3]  = '{6'h30, 24'hFCFCFC};
        vec[4]  = '{6'h3C, 24'h00FCFC};
        vec[5]  = '{6'h0D, 24'h000000};
        vec[6]  = '{6'h0E, 24'h000000};
        vec[7]  = '{6'h0F, 24'h000000};
        vec[8]  = '{6'h1D, 24'h000000};
        vec[9]  = '{6'h1E, 24'h000000};
        vec[10] = '{6'h1F, 24'h000000};
        vec[11] = '{6'h2E, 24'h000000};
        vec[12] = '{6'h2F, 24'h000000};
        vec[13] = '{6'h3E, 24'h000000};
        vec[14] = '{6'h3F, 24'h000000};

        rst = 1'b1; wr_en = 1'b0; wr_x = '0; wr_color = '0;
        wr_line_done = 1'b0; rd_start = 1'b0; rd_pix_en = 1'b0;
        tick(); tick();
        chk("rst_busy",     32'(rd_busy), 0);
        chk("rst_ready",    32'(line_ready), 0);
        chk("rst_valid",    32'(rgb_valid), 0);
        chk("rst_rgb",      32'({red, green, blue}), 0);
        chk("rst_overrun",  32'(overrun), 0);
        chk("rst_underrun", 32'(underrun), 0);
        rst = 1'b0;
        tick();

        // Ramp line: colour = x[5:0]
        write_line(0, 6'h00);
        pulse_done();
        chk("t1_ready", 32'(line_ready), 1);
        replay(-1, -1, strobes, rdy);
        chk("t1_strobes",  32'(strobes), NPIX);
        chk("t1_pulses",   32'(cap.size()), NPIX);
        chk("t1_pix0",     32'(cap[0]), 32'h7C7C7C);
        chk("t1_pix1",     32'(cap[1]), 32'h7C7C7C);
        chk("t1_pix2",     32'(cap[2]), 32'h0000FC);
        chk("t1_pix3",     32'(cap[3]), 32'h0000FC);
        chk("t1_pix64",    32'(cap[64]), 32'hF8F8F8);
        chk("t1_pix96",    32'(cap[96]), 32'hFCFCFC);
        chk("t1_ready_end", 32'(rdy), 0);
        chk("t1_underrun", 32'(underrun), 0);

        // Palette table: each column pixel repeated SCALE times
        write_line(2, 6'h00);
        pulse_done();
        replay(-1, -1, strobes, rdy);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("lut_%02h_a", vec[i].idx), 32'(cap[2*i]),   32'(vec[i].rgb));
            chk($sformatf("lut_%02h_b", vec[i].idx), 32'(cap[2*i+1]), 32'(vec[i].rgb));
        end

        // Swap requested mid-replay is deferred to the end of the line
        write_line(1, 6'h01);
        pulse_done();
        write_line(1, 6'h20);
        replay(100, -1, strobes, rdy);
        chk("t2_ready_after", 32'(rdy), 1);
        chk("t2_lineA",       32'(count_not(24'h0000FC)), 0);
        chk("t2_overrun",     32'(overrun), 0);
        replay(-1, -1, strobes, rdy);
        chk("t2_lineB",       32'(count_not(24'hF8F8F8)), 0);
        chk("t2_ready_end",   32'(rdy), 0);

        // Two completions during one replay: overrun, single swap
        write_line(1, 6'h30);
        replay(50, 150, strobes, rdy);
        chk("t3_overrun",     32'(overrun), 1);
        chk("t3_ready_after", 32'(rdy), 1);
        chk("t3_lineB",       32'(count_not(24'hF8F8F8)), 0);
        replay(-1, -1, strobes, rdy);
        chk("t3_lineC",       32'(count_not(24'hFCFCFC)), 0);
        chk("t3_ready_end",   32'(rdy), 0);

        // Strobe gaps: rgb_valid mirrors strobes two cycles later
        write_line(2, 6'h00);
        pulse_done();
        en5  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        pix5 = '{24'h7C7C7C, 24'h7C7C7C, 24'h0000FC, 24'h0000FC};
        cap.delete();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        exp_cur  = '0;
        nseen    = 0;
        for (int i = 0; i < 10; i++) begin
            rd_pix_en = en5[i];
            tick();
            expv = (i > 0) ? en5[i-1] : 1'b0;
            chk($sformatf("t5_valid_%0d", i), 32'(rgb_valid), 32'(expv));
            if (expv) begin
                exp_cur = pix5[nseen];
                nseen++;
            end
            if (i > 0) chk($sformatf("t5_rgb_%0d", i), 32'({red, green, blue}), 32'(exp_cur));
        end
        chk("t5_busy_gap", 32'(rd_busy), 1);
        rd_pix_en = 1'b1;
        for (int n = 0; n < 2000 && rd_busy; n++) tick();
        rd_pix_en = 1'b0;
        repeat (3) tick();
        chk("t5_pulses", 32'(cap.size()), NPIX);

        // Reset mid-replay at display pixel 100
        write_line(2, 6'h00);
        pulse_done();
        rd_start = 1'b1;
        tick();
        rd_start  = 1'b0;
        rd_pix_en = 1'b1;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cap.delete();
        chk("t6_busy",     32'(rd_busy), 0);
        chk("t6_ready",    32'(line_ready), 0);
        chk("t6_valid",    32'(rgb_valid), 0);
        chk("t6_rgb",      32'({red, green, blue}), 0);
        chk("t6_overrun",  32'(overrun), 0);
        chk("t6_underrun", 32'(underrun), 0);
        repeat (5) tick();
        rd_pix_en = 1'b0;
        chk("t6_no_pulse", 32'(cap.size()), 0);

        // Replay with no ready line right after reset
        replay(-1, -1, strobes, rdy);
        chk("t4_underrun", 32'(underrun), 1);
        chk("t4_strobes",  32'(strobes), NPIX);
        chk("t4_pulses",   32'(cap.size()), NPIX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
